// File: rtl/regfile32_write.sv
`default_nettype none
// ============================================================================
// Module      : regfile32_write
// Description : 32 x 32-bit CPU register file. Writes go through a 5-to-32
//               one-hot decoder; reads use two independent combinational
//               32:1 selectors. Register 0 is hardwired to zero. A registered
//               one-hot strobe of the last committed write and a saturating
//               16-bit committed-write counter are provided for observation.
//               Optional feature macro: REGFILE_BYPASS_EN (write-to-read
//               forwarding on both read ports).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile32_write (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr_a,
    input  logic [4:0]  rd_addr_b,
    output logic [31:0] rd_data_a,
    output logic [31:0] rd_data_b,
    output logic [31:0] wr_onehot,
    output logic [15:0] wr_count
);

    localparam int          C_NREGS     = 32;
    localparam logic [15:0] C_COUNT_MAX = 16'hFFFF;

    // Per-register write enables from the one-hot decoder (bit 0 never set).
    logic [31:0] w_en;
    // A write that actually changes architectural state.
    logic        w_commit;
    // Storage for registers 1..31; register 0 has no storage at all.
    logic [31:0] r_regs [1:C_NREGS-1];
    // Uniform 0..31 view of the register file used by the read selectors.
    logic [31:0] w_file [0:C_NREGS-1];
    // Stored contents seen by each read port, before any forwarding.
    logic [31:0] w_stored_a;
    logic [31:0] w_stored_b;
    logic [31:0] r_onehot;
    logic [15:0] r_count;

    // The AND with wr_en comes first so an unknown address while idle
    // resolves to a zero enable and cannot disturb any register.
    assign w_en[0] = 1'b0;
    generate
        for (genvar k = 1; k < C_NREGS; k++) begin : g_dec
            assign w_en[k] = wr_en & (wr_addr == 5'(k));
        end
    endgenerate

    assign w_commit = |w_en;

    // Register 0 reads as a constant zero; the rest map to storage.
    generate
        for (genvar k = 0; k < C_NREGS; k++) begin : g_file
            if (k == 0) begin : g_zero
                assign w_file[k] = 32'h0;
            end else begin : g_reg
                assign w_file[k] = r_regs[k];
            end
        end
    endgenerate

    // Register storage: each register captures wr_data when its enable is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k < C_NREGS; k++) begin
                r_regs[k] <= 32'h0;
            end
        end else begin
            for (int k = 1; k < C_NREGS; k++) begin
                if (w_en[k]) begin
                    r_regs[k] <= wr_data;
                end
            end
        end
    end

    // One-hot strobe of the write committed on the most recent edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_onehot <= 32'h0;
        end else begin
            r_onehot <= w_en;
        end
    end

    // Saturating committed-write counter; holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 16'h0;
        end else if (w_commit && (r_count != C_COUNT_MAX)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign w_stored_a = w_file[rd_addr_a];
    assign w_stored_b = w_file[rd_addr_b];

`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write to a port reading the same register.
    // w_commit already excludes register 0, so reads of 0 stay zero.
    always_comb begin
        rd_data_a = w_stored_a;
        rd_data_b = w_stored_b;
        if (w_commit && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end
        if (w_commit && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end
    end
`else
    // Read ports expose stored contents only; a write shows after its edge.
    always_comb begin
        rd_data_a = w_stored_a;
        rd_data_b = w_stored_b;
    end
`endif

    assign wr_onehot = r_onehot;
    assign wr_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile32_write.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile32_write
// Description : Self-checking bench for regfile32_write. Writes are driven on
//               the falling edge, expected state is pushed to a scoreboard
//               queue, and results are popped and compared 1 time unit after
//               the rising edge. Honours REGFILE_BYPASS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile32_write;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic [31:0] wr_onehot;
    logic [15:0] wr_count;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] onehot;
        logic [15:0] count;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_regs [0:31];
    logic [15:0] m_count;
    int          checks;
    int          failures;

    regfile32_write dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_onehot (wr_onehot),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
        m_count = 16'h0;
    endtask

    // Drive one write request across a single edge and queue the expected state.
    task automatic drive_write(input logic en, input logic [4:0] addr, input logic [31:0] data);
        exp_t e;
        @(negedge clk);
        wr_en   = en;
        wr_addr = addr;
        wr_data = data;
        e.onehot = 32'h0;
        if (en && addr != 5'd0) begin
            m_regs[addr] = data;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            e.onehot = 32'h1 << addr;
        end
        e.addr  = addr;
        e.data  = m_regs[addr];
        e.count = m_count;
        sb.push_back(e);
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        wr_addr = 5'd0;
        wr_data = 32'h0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = 5'd0;
        wr_data   = 32'h0;
        rd_addr_a = 5'd5;
        rd_addr_b = 5'd31;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rd_data_a !== 32'h0) begin failures++; $display("FAIL reset_rd_a got=%h exp=%h", rd_data_a, 32'h0); end
        checks++;
        if (rd_data_b !== 32'h0) begin failures++; $display("FAIL reset_rd_b got=%h exp=%h", rd_data_b, 32'h0); end
        checks++;
        if (wr_onehot !== 32'h0) begin failures++; $display("FAIL reset_onehot got=%h exp=%h", wr_onehot, 32'h0); end
        checks++;
        if (wr_count !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=%h", wr_count, 16'h0); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_all();
        exp_t e;
        for (int k = 1; k < 32; k++) begin
            drive_write(1'b1, 5'(k), 32'hA5A50000 + 32'(k));
            e = sb.pop_front();
            rd_addr_a = e.addr;
            rd_addr_b = e.addr;
            #1;
            checks++;
            if (rd_data_a !== e.data) begin failures++; $display("FAIL wall_rd_a[%0d] got=%h exp=%h", k, rd_data_a, e.data); end
            checks++;
            if (rd_data_b !== e.data) begin failures++; $display("FAIL wall_rd_b[%0d] got=%h exp=%h", k, rd_data_b, e.data); end
            checks++;
            if (wr_onehot !== e.onehot) begin failures++; $display("FAIL wall_onehot[%0d] got=%h exp=%h", k, wr_onehot, e.onehot); end
            checks++;
            if (wr_count !== e.count) begin failures++; $display("FAIL wall_count[%0d] got=%0d exp=%0d", k, wr_count, e.count); end
        end
        checks++;
        if (wr_count !== 16'd31) begin failures++; $display("FAIL wall_final_count got=%0d exp=%0d", wr_count, 31); end
        // The strobe must drop on the first idle edge.
        @(posedge clk);
        #1;
        checks++;
        if (wr_onehot !== 32'h0) begin failures++; $display("FAIL wall_onehot_clear got=%h exp=%h", wr_onehot, 32'h0); end
        // Every register should still hold its pattern on both ports.
        for (int k = 0; k < 32; k++) begin
            rd_addr_a = 5'(k);
            rd_addr_b = 5'(31 - k);
            #1;
            checks++;
            if (rd_data_a !== m_regs[k]) begin failures++; $display("FAIL wall_sweep_a[%0d] got=%h exp=%h", k, rd_data_a, m_regs[k]); end
            checks++;
            if (rd_data_b !== m_regs[31-k]) begin failures++; $display("FAIL wall_sweep_b[%0d] got=%h exp=%h", 31 - k, rd_data_b, m_regs[31-k]); end
        end
    endtask

    task automatic test_reg0();
        exp_t e;
        drive_write(1'b1, 5'd0, 32'hFFFFFFFF);
        e = sb.pop_front();
        rd_addr_a = 5'd0;
        rd_addr_b = 5'd0;
        #1;
        checks++;
        if (rd_data_a !== 32'h0) begin failures++; $display("FAIL reg0_rd_a got=%h exp=%h", rd_data_a, 32'h0); end
        checks++;
        if (wr_onehot !== e.onehot) begin failures++; $display("FAIL reg0_onehot got=%h exp=%h", wr_onehot, e.onehot); end
        checks++;
        if (wr_count !== e.count) begin failures++; $display("FAIL reg0_count got=%0d exp=%0d", wr_count, e.count); end
    endtask

    task automatic test_disabled();
        exp_t e;
        drive_write(1'b0, 5'd7, 32'hDEADBEEF);
        e = sb.pop_front();
        rd_addr_a = 5'd7;
        #1;
        checks++;
        if (rd_data_a !== e.data) begin failures++; $display("FAIL dis_rd7 got=%h exp=%h", rd_data_a, e.data); end
        checks++;
        if (wr_count !== e.count) begin failures++; $display("FAIL dis_count got=%0d exp=%0d", wr_count, e.count); end
        checks++;
        if (wr_onehot !== 32'h0) begin failures++; $display("FAIL dis_onehot got=%h exp=%h", wr_onehot, 32'h0); end
        // Unknown address while idle must leave every register intact.
        @(negedge clk);
        wr_en   = 1'b0;
        wr_addr = 5'bxxxxx;
        wr_data = 32'h12345678;
        @(posedge clk);
        #1;
        wr_addr = 5'd0;
        for (int k = 0; k < 32; k++) begin
            rd_addr_a = 5'(k);
            #1;
            checks++;
            if (rd_data_a !== m_regs[k]) begin failures++; $display("FAIL xaddr_rd[%0d] got=%h exp=%h", k, rd_data_a, m_regs[k]); end
        end
        checks++;
        if (wr_count !== m_count) begin failures++; $display("FAIL xaddr_count got=%0d exp=%0d", wr_count, m_count); end
    endtask

    task automatic test_same_cycle();
        exp_t        e;
        logic [31:0] before_exp;
        drive_write(1'b1, 5'd3, 32'h1);
        e = sb.pop_front();
        rd_addr_a = 5'd3;
        #1;
        checks++;
        if (rd_data_a !== e.data) begin failures++; $display("FAIL same_pre_rd got=%h exp=%h", rd_data_a, e.data); end
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'h2;
        #1;
`ifdef REGFILE_BYPASS_EN
        before_exp = 32'h2;
`else
        before_exp = 32'h1;
`endif
        checks++;
        if (rd_data_a !== before_exp) begin failures++; $display("FAIL same_before_edge got=%h exp=%h", rd_data_a, before_exp); end
        m_regs[3] = 32'h2;
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        wr_addr = 5'd0;
        wr_data = 32'h0;
        #1;
        checks++;
        if (rd_data_a !== 32'h2) begin failures++; $display("FAIL same_after_edge got=%h exp=%h", rd_data_a, 32'h2); end
        checks++;
        if (wr_count !== m_count) begin failures++; $display("FAIL same_count got=%0d exp=%0d", wr_count, m_count); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        rd_addr_a = 5'd9;
        rd_addr_b = 5'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 5'd9;
            wr_data = 32'hC0DE0000 + 32'(i);
            m_regs[9] = wr_data;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            e.addr = 5'd9; e.data = m_regs[9]; e.onehot = 32'h1 << 9; e.count = m_count;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (rd_data_b !== e.data) begin failures++; $display("FAIL b2b_rd[%0d] got=%h exp=%h", i, rd_data_b, e.data); end
            checks++;
            if (wr_onehot !== e.onehot) begin failures++; $display("FAIL b2b_onehot[%0d] got=%h exp=%h", i, wr_onehot, e.onehot); end
            checks++;
            if (wr_count !== e.count) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=%0d", i, wr_count, e.count); end
        end
        wr_en = 1'b0;
        #1;
        checks++;
        if (rd_data_a !== 32'hC0DE0002) begin failures++; $display("FAIL b2b_last_wins got=%h exp=%h", rd_data_a, 32'hC0DE0002); end
    endtask

    task automatic test_async_reset();
        rd_addr_a = 5'd5;
        rd_addr_b = 5'd31;
        drive_write(1'b1, 5'd5, 32'h55555555);
        void'(sb.pop_front());
        // Assert reset well away from any edge; outputs must clear immediately.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_data_a !== 32'h0) begin failures++; $display("FAIL areset_rd_a got=%h exp=%h", rd_data_a, 32'h0); end
        checks++;
        if (rd_data_b !== 32'h0) begin failures++; $display("FAIL areset_rd_b got=%h exp=%h", rd_data_b, 32'h0); end
        checks++;
        if (wr_count !== 16'h0) begin failures++; $display("FAIL areset_count got=%0d exp=%0d", wr_count, 0); end
        checks++;
        if (wr_onehot !== 32'h0) begin failures++; $display("FAIL areset_onehot got=%h exp=%h", wr_onehot, 32'h0); end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 5'((i % 31) + 1);
            wr_data = 32'(i);
            m_regs[wr_addr] = wr_data;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            @(posedge clk);
            #1;
            if (m_count >= 16'hFFFC) begin
                checks++;
                if (wr_count !== m_count) begin failures++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", i, wr_count, m_count); end
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (wr_count !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=%h", wr_count, 16'hFFFF); end
        rd_addr_a = 5'd1;
        #1;
        checks++;
        if (rd_data_a !== m_regs[1]) begin failures++; $display("FAIL sat_rd1 got=%h exp=%h", rd_data_a, m_regs[1]); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_all();
        test_reg0();
        test_disabled();
        test_same_cycle();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
